// File: rtl/switch_egress_port_if.sv
// rtl/switch_egress_port_if.sv - packet-in / packet-out handshake bundle of the switch egress port
interface switch_egress_port_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int PACKET_WIDTH = DATA_WIDTH + 2 * ADDR_WIDTH;

  // Mux side: packet {data, target, source} plus accept indication to the arbiter
  logic                    valid_in;
  logic [PACKET_WIDTH-1:0] pkt_in;
  logic                    egress_ready;

  // Downstream side: registered packet fields on a valid/ready handshake
  logic                    valid_out;
  logic                    ready_out;
  logic [ADDR_WIDTH-1:0]   source_out;
  logic [ADDR_WIDTH-1:0]   target_out;
  logic [DATA_WIDTH-1:0]   data_out;

  modport master (
    output valid_in, pkt_in, ready_out,
    input  egress_ready, valid_out, source_out, target_out, data_out
  );

  modport slave (
    input  valid_in, pkt_in, ready_out,
    output egress_ready, valid_out, source_out, target_out, data_out
  );
endinterface

// File: rtl/switch_egress_port.sv
// rtl/switch_egress_port.sv - egress port: address check, FIFO buffer, registered output stage (stats under EGRESS_STATS_EN)
module switch_egress_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PORT_ID    = 0,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  switch_egress_port_if.slave  bus,
  output logic                 misroute_err,
  output logic                 overflow_err,
  output logic [CNT_WIDTH-1:0] tx_count,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int PACKET_WIDTH = DATA_WIDTH + 2 * ADDR_WIDTH;
  localparam int AW           = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;
  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_source;
  logic [ADDR_WIDTH-1:0]   r_target;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_misroute;
  logic                    r_overflow;

  logic                    w_full;
  logic                    w_empty;
  logic [ADDR_WIDTH-1:0]   w_target_in;
  logic                    w_addr_match;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_misroute;
  logic                    w_overflow;
  logic [PACKET_WIDTH-1:0] w_head;

  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_target_in  = bus.pkt_in[ADDR_WIDTH +: ADDR_WIDTH];
  assign w_addr_match = (w_target_in == ADDR_WIDTH'(PORT_ID));
  assign w_head       = r_mem[r_rd_ptr];

  // Misroute outranks the full check; a flush cycle swallows the input silently
  assign w_misroute = bus.valid_in && !flush && !w_addr_match;
  assign w_overflow = bus.valid_in && !flush && w_addr_match && w_full;
  assign w_push     = bus.valid_in && !flush && w_addr_match && !w_full;

  assign bus.egress_ready = !w_full;
  assign bus.valid_out    = (r_state == SEND);
  assign bus.source_out   = r_source;
  assign bus.target_out   = r_target;
  assign bus.data_out     = r_data;
  assign misroute_err     = r_misroute;
  assign overflow_err     = r_overflow;

  // Output stage sequencing: refill on an empty slot or on a completed handshake
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (bus.ready_out) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) begin
      w_pop        = 1'b0;
      w_state_next = IDLE;
    end
  end

  // Packet storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.pkt_in;
    end
  end

  // FIFO pointers and occupancy; full is judged before this edge's pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register and output packet register, loaded on every pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_source <= '0;
      r_target <= '0;
      r_data   <= '0;
    end else if (flush) begin
      r_state  <= IDLE;
      r_source <= '0;
      r_target <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_source <= w_head[ADDR_WIDTH-1:0];
        r_target <= w_head[ADDR_WIDTH +: ADDR_WIDTH];
        r_data   <= w_head[2*ADDR_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Drop indications, one cycle after the offending packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misroute <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_misroute <= w_misroute;
      r_overflow <= w_overflow;
    end
  end

`ifdef EGRESS_STATS_EN
  logic [CNT_WIDTH-1:0] r_tx_count;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic                 w_handshake;
  logic                 w_drop;

  assign w_handshake = (r_state == SEND) && bus.ready_out && !flush;
  assign w_drop      = w_misroute || w_overflow;

  // Saturating statistics; flush leaves them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_handshake && (r_tx_count != '1)) begin
        r_tx_count <= r_tx_count + CNT_WIDTH'(1);
      end
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
    end
  end

  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`else
  assign tx_count   = '0;
  assign drop_count = '0;
`endif

endmodule

// File: doc/switch_egress_port.md
Name: switch_egress_port

Overview:
- Output-side counterpart of the ingress switch port. It receives packets that the 4:1 mux forwards after an input port is granted.
- It checks that each packet is addressed to this port, buffers it in a small FIFO, and drives it off the switch on a valid/ready handshake with registered outputs.
- It tells the arbiter whether it can accept packets (egress_ready). It flags misrouted and overflowed packets.
- Packet format comes from packet_pkg: {data, target, source}, PACKET_WIDTH = DATA_WIDTH + 2*ADDR_WIDTH.

Parameters:
- PORT_ID, 0, address this egress port owns; compared against the target field.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of FIFO and output stage.
- valid_in  in  1  packet present on pkt_in from the mux.
- pkt_in  in  PACKET_WIDTH  {data, target, source}.
- egress_ready  out  1  to arbiter; high = FIFO not full.
- valid_out  out  1  output packet valid.
- ready_out  in  1  downstream accepts the packet.
- source_out  out  ADDR_WIDTH  registered source field.
- target_out  out  ADDR_WIDTH  registered target field.
- data_out  out  DATA_WIDTH  registered data field.
- misroute_err  out  1  one-cycle pulse: packet dropped, target != PORT_ID.
- overflow_err  out  1  one-cycle pulse: packet dropped, FIFO full.
- tx_count  out  CNT_WIDTH  packets delivered (see Optional Feature).
- drop_count  out  CNT_WIDTH  packets dropped (see Optional Feature).

Behaviour:
- Reset (rst high, async) and state after it:
  - FIFO pointers and count are 0.
  - State is IDLE.
  - valid_out, misroute_err and overflow_err are 0.
  - source_out, target_out and data_out are 0.
  - Counters are 0.
  - egress_ready is 1 (it is combinational: egress_ready = !full).
- Reset mid-transfer discards every buffered packet and the packet held in the output stage.
- Input side, evaluated each edge where valid_in = 1:
  - target != PORT_ID: not pushed; misroute_err = 1 the next cycle. The misroute check has priority over the full check.
  - target == PORT_ID and FIFO full: not pushed; overflow_err = 1 the next cycle.
  - Otherwise the packet is pushed.
- Push while full is rejected even if a pop happens in the same cycle (full is judged on the pre-edge count). Push and pop in the same cycle while not full leaves the count unchanged.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits wide.
- FSM, 2 states:
  - IDLE: valid_out = 0. If the FIFO is non-empty, pop the head into the output register, set valid_out = 1 and go to SEND.
  - SEND: valid_out = 1 and the outputs are held stable while ready_out = 0.
  - SEND on a handshake (valid_out & ready_out): if the FIFO is non-empty, pop the next packet into the output register in the same cycle and stay in SEND (back-to-back, no bubble). Otherwise set valid_out = 0 and go to IDLE.
- Latency: a packet sampled at edge k into an empty FIFO with IDLE state gives valid_out = 1 after edge k+1. Steady-state throughput is 1 packet per cycle while ready_out = 1.
- A handshake in the same cycle as a push into an empty FIFO: that packet is loaded at the next edge.
- flush (priority below rst, above everything else):
  - At the edge: empty the FIFO, set valid_out = 0, go to IDLE.
  - Any valid_in in the flush cycle is discarded and counted as neither error nor drop.
  - Counters are kept.
- egress_ready = 0 obliges the arbiter not to grant this destination. A packet arriving anyway is handled as overflow above.

Optional Feature:
- Macro: EGRESS_STATS_EN.
- Defined:
  - tx_count increments on each output handshake.
  - drop_count increments on each misroute or overflow drop.
  - Both counters saturate at all-ones and do not wrap.
  - Both clear only on rst.
- Not defined: tx_count and drop_count are tied to 0 and no counter flops are synthesised. All other behaviour is identical.

Test Plan:
Test values: ADDR_WIDTH=4, DATA_WIDTH=8, PORT_ID=2, DEPTH=4.
1. Single packet: after reset, valid_in with source=1, target=2, data=0xA5 at edge 0, ready_out=1 -> valid_out=1 after edge 1 with outputs 1/2/0xA5. valid_out=0 after edge 2. tx_count=1 (stats on).
2. Misroute: target=3 -> misroute_err pulses 1 cycle. Nothing is output. drop_count=1. egress_ready stays 1.
3. Backpressure and overflow: ready_out=0, push 5 packets with data 0x10-0x14 -> 0x10 sits in the output stage and 4 are buffered. The 6th packet (0x15) gives overflow_err and egress_ready=0. Releasing ready_out delivers 0x10-0x14 in order on consecutive cycles.
4. Back-to-back: ready_out=1 and valid_in every cycle with data 0..7 -> valid_out high continuously from edge 1 with data 0..7 in order. No errors.
5. Flush: 3 packets buffered and ready_out=0, then flush for 1 cycle -> valid_out=0 and egress_ready=1 next cycle. No further output. Counters are unchanged.
6. Async reset mid-SEND: assert rst between edges -> valid_out drops immediately without waiting for a clock. All outputs and counters are 0 and egress_ready=1.
